// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state codes
// and width helpers.
package mult_pkg;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    function automatic int unsigned prod_width(input int unsigned width);
        return 2 * width;
    endfunction

    // Counter must hold WIDTH itself, not just WIDTH-1.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_mult_ctrl.sv
// Control for seq_mult: IDLE/RUN/DONE sequencing, bit counter and the
// busy/done decode. Emits load on an accepted start and finish on the last RUN cycle.
module seq_mult_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic done,
    output logic load,
    output logic finish
);

    localparam int unsigned CW = cnt_width(WIDTH);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign load   = start && ((state_q == StIdle) || (state_q == StDone));
    assign finish = (state_q == StRun) && (cnt_q == CW'(1));
    assign busy   = (state_q == StRun);
    assign done   = (state_q == StDone);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    cnt_d   = CW'(WIDTH);
                end
            end
            StRun: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_d == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (start) begin
                    state_d = StRun;
                    cnt_d   = CW'(WIDTH);
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, unsigned or
// two's-complement per operation. Signed operands are multiplied as magnitudes.
module seq_mult
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned PW = prod_width(WIDTH);

    logic             load, finish;
    logic [WIDTH-1:0] mcand_q, mplier_q;
    logic             sign_q;
    logic [PW-1:0]    acc_q, prod_q;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   sum;
    logic [PW-1:0]    acc_step;

    seq_mult_ctrl #(
        .WIDTH (WIDTH)
    ) u_ctrl (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .load   (load),
        .finish (finish)
    );

    // Most negative value negates to itself, which is the correct magnitude.
    always_comb begin
        abs_a = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        abs_b = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    end

    // Add into the upper half, then shift the whole accumulator right.
    always_comb begin
        sum      = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, (mplier_q[0] ? mcand_q : '0)};
        acc_step = {sum, acc_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            sign_q   <= 1'b0;
            acc_q    <= '0;
            prod_q   <= '0;
        end else begin
            if (load) begin
                mcand_q  <= abs_a;
                mplier_q <= abs_b;
                sign_q   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                acc_q    <= '0;
            end else if (busy) begin
                acc_q    <= acc_step;
                mplier_q <= mplier_q >> 1;
            end
            if (finish) begin
                prod_q <= sign_q ? (~acc_step + PW'(1)) : acc_step;
            end
        end
    end

    assign product = prod_q;

endmodule

// File: tb/tb_seq_mult.sv
// Scoreboard bench for seq_mult at WIDTH=8 (directed + random) and WIDTH=4
// (exhaustive), checked against an integer-arithmetic reference model.
module tb_seq_mult;

    logic        clk;
    logic        rst8_n, start8, sm8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;
    logic        rst4_n, start4, sm4, busy4, done4;
    logic [3:0]  a4, b4;
    logic [7:0]  product4;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          done_cyc8 = 0;
    logic [31:0] last8 = '0;
    logic [31:0] last4 = '0;
    logic [31:0] q8[$];
    logic [31:0] q4[$];

    seq_mult #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst8_n), .start(start8), .signed_mode(sm8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .product(product8)
    );

    seq_mult #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst4_n), .start(start4), .signed_mode(sm4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .product(product4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Product of the operands as integers, reduced modulo 2^(2w).
    function automatic logic [31:0] ref_mul(input int unsigned w, input logic [15:0] av,
                                            input logic [15:0] bv, input bit sm);
        longint va, vb, p;
        va = longint'(av);
        vb = longint'(bv);
        if (sm && av[w-1]) va = va - (longint'(1) << w);
        if (sm && bv[w-1]) vb = vb - (longint'(1) << w);
        p = va * vb;
        return 32'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    always @(posedge clk) begin
        #1;
        chk("w8 busy&done", 32'(busy8 & done8), 32'd0);
        chk("w4 busy&done", 32'(busy4 & done4), 32'd0);
        if (done8) begin
            if (q8.size() == 0) chk("w8 unexpected done", 32'd1, 32'd0);
            else chk("w8 product", 32'(product8), q8.pop_front());
        end
        if (done4) begin
            if (q4.size() == 0) chk("w4 unexpected done", 32'd1, 32'd0);
            else chk("w4 product", 32'(product4), q4.pop_front());
        end
    end

    // Called mid-cycle in IDLE or DONE; returns mid-cycle in the resulting DONE cycle.
    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input bit sm);
        logic [31:0] exp;
        exp = ref_mul(8, 16'(av), 16'(bv), sm);
        start8 = 1'b1; a8 = av; b8 = bv; sm8 = sm;
        q8.push_back(exp);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            chk("w8 busy", 32'(busy8), 32'd1);
            chk("w8 done early", 32'(done8), 32'd0);
            chk("w8 product hold", 32'(product8), last8);
            start8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
        end
        @(posedge clk); #1;
        chk("w8 done", 32'(done8), 32'd1);
        chk("w8 busy end", 32'(busy8), 32'd0);
        last8 = exp;
        done_cyc8 = cyc;
        start8 = 1'b0;
    endtask

    task automatic run4(input logic [3:0] av, input logic [3:0] bv, input bit sm);
        logic [31:0] exp;
        exp = ref_mul(4, 16'(av), 16'(bv), sm);
        start4 = 1'b1; a4 = av; b4 = bv; sm4 = sm;
        q4.push_back(exp);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("w4 busy", 32'(busy4), 32'd1);
            chk("w4 product hold", 32'(product4), last4);
            start4 = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom); sm4 = 1'($urandom);
        end
        @(posedge clk); #1;
        chk("w4 done", 32'(done4), 32'd1);
        last4 = exp;
        start4 = 1'b0;
    endtask

    initial begin
        int c0, c1;
        rst8_n = 1'b0; start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
        rst4_n = 1'b0; start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy8), 32'd0);
        chk("reset done", 32'(done8), 32'd0);
        chk("reset product", 32'(product8), 32'd0);
        chk("reset w4 product", 32'(product4), 32'd0);
        rst8_n = 1'b1; rst4_n = 1'b1;
        @(posedge clk); #1;

        run8(8'd13, 8'd11, 1'b0);
        run8(8'hFF, 8'hFF, 1'b0);
        run8(8'hFF, 8'hFF, 1'b1);
        run8(8'h80, 8'h80, 1'b1);
        run8(8'h80, 8'h7F, 1'b1);
        run8(8'hFD, 8'h05, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("idle done", 32'(done8), 32'd0);

        // Three back-to-back operations: done must recur every WIDTH+1 cycles.
        run8(8'($urandom), 8'($urandom), 1'b0);
        c0 = done_cyc8;
        run8(8'($urandom), 8'($urandom), 1'b1);
        c1 = done_cyc8;
        chk("b2b spacing 1", 32'(c1 - c0), 32'd9);
        run8(8'($urandom), 8'($urandom), 1'b0);
        chk("b2b spacing 2", 32'(done_cyc8 - c1), 32'd9);

        // Reset in cycle N+4 of 200*200 abandons the operation.
        start8 = 1'b1; a8 = 8'd200; b8 = 8'd200; sm8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst8_n = 1'b0;
        @(posedge clk); #1;
        chk("mid-run reset busy", 32'(busy8), 32'd0);
        chk("mid-run reset done", 32'(done8), 32'd0);
        chk("mid-run reset product", 32'(product8), 32'd0);
        rst8_n = 1'b1;
        last8 = '0;
        @(posedge clk); #1;
        run8(8'd7, 8'd6, 1'b0);
        run8(8'd0, 8'($urandom), 1'b1);

        for (int i = 0; i < 30; i++) begin
            run8(8'($urandom), 8'($urandom), 1'($urandom));
            if (i % 7 == 0) begin
                @(posedge clk); #1;
            end
        end

        for (int m = 0; m < 2; m++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    run4(4'(x), 4'(y), 1'(m));
                end
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("w8 queue drained", 32'(q8.size()), 32'd0);
        chk("w4 queue drained", 32'(q4.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_mult.md
# seq_mult

Parametrised sequential shift-add multiplier, successor to the fixed 4x4 combinational array multiplier. It multiplies two WIDTH-bit operands, unsigned or two's-complement selectable per operation. It uses a start/busy/done handshake and one adder, so area stays flat as WIDTH grows. It sits behind the TinyTapeout top-level wrapper, which drives operands from ui_in/uio_in and shows the product on uo_out/uio_out.

## Interface
- WIDTH, 8: operand width in bits; legal range 2..16.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request; sampled only in IDLE or DONE.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with start.
- a  input  WIDTH  multiplicand; captured with start.
- b  input  WIDTH  multiplier; captured with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; product valid and new.
- product  output  2*WIDTH  result register; holds the last completed result.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE --start--> RUN.
  - RUN --(bit counter = 0)--> DONE.
  - DONE --start--> RUN, otherwise DONE --> IDLE.
- Capture on accepted start:
  - signed_mode=1: store |a| and |b| as WIDTH-bit unsigned magnitudes. The most negative value maps to 2^(WIDTH-1), which fits. Store sign flag = a[MSB] ^ b[MSB].
  - signed_mode=0: store a and b directly; sign flag = 0.
  - Clear the 2*WIDTH accumulator. Load the bit counter with WIDTH.
- RUN, each cycle, on multiplier LSB:
  - If the LSB is 1, add the multiplicand, shifted left by the number of bits already processed, into the accumulator. Equivalently, add into the upper half and shift right.
  - Shift the multiplier right and decrement the counter.
- Entering DONE: product <= sign flag ? (~acc + 1) : acc, truncated to 2*WIDTH bits. Signed results are exact two's-complement 2*WIDTH values. Unsigned results are exact.
- start while busy=1 is ignored; operands are not recaptured.
- signed_mode, a and b are don't-care except in the cycle start is accepted.
- Outputs are registered or decoded from the registered state; no combinational path from inputs to outputs.

## Timing
- Reset (rst_n low at a clock edge): state=IDLE, busy=0, done=0, product=0, accumulator and counter cleared. Reset mid-RUN abandons the operation with no done pulse.
- Latency: start high in cycle N (IDLE or DONE).
  - busy=1 in cycles N+1 .. N+WIDTH.
  - done=1 and new product in cycle N+WIDTH+1.
- Throughput: one result per WIDTH+1 cycles when start is held high or re-asserted in the DONE cycle. Back-to-back operation has no IDLE gap.
- done is high for exactly one cycle per accepted start. busy and done are never high together.
- product changes only on entry to DONE or on reset.

## Structure
- Shared package mult_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - localparam PW = 2*WIDTH helper function;
  - counter width = $clog2(WIDTH+1).
- One sub-module, seq_mult_ctrl: FSM, bit counter, and the busy/done decode.
- Datapath (operand registers, sign logic, adder, shifter, final negate) lives in seq_mult.

## Test plan
- WIDTH=8, unsigned, a=13, b=11, start in cycle N -> busy in N+1..N+8; done in N+9 only; product=0x008F.
- WIDTH=8, unsigned 255*255 -> 0xFE01. Signed 255*255 (-1*-1) -> 0x0001. Signed 0x80*0x80 -> 0x4000. Signed 0x80*0x7F -> 0xC080. Signed 0xFD*0x05 -> 0xFFF1.
- WIDTH=8, start held high for 3 operations -> done pulses every 9 cycles. Each product matches its operands. start pulses during busy change nothing.
- WIDTH=8, reset asserted in cycle N+4 of a 200*200 operation -> next cycle busy=0, done=0, product=0. A fresh 7*6 then gives 0x002A.
- WIDTH=4, exhaustive 256 unsigned and 256 signed operand pairs -> all products match the reference model. 15*15=225 matches the legacy 4x4 array multiplier. 0*x=0 in both modes.
